// File: rtl/bcd_timer_chain_if.sv
// bcd_timer_chain_if
//   Groups the control strobes, preset bus and display outputs of the
//   BCD timer chain so that the controller and the counter share one port.
//
//   master : drives tick/run/dir/load/load_value, observes the outputs
//   slave  : the counter; observes the controls, drives digits,
//            hex_display, carry_out, done and expired
interface bcd_timer_chain_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      tick;
    logic                      run;
    logic                      dir;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_value;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [8*NUM_DIGITS-1:0]   hex_display;
    logic                      carry_out;
    logic                      done;
    logic                      expired;

    modport master (
        output tick, run, dir, load, load_value,
        input  digits, hex_display, carry_out, done, expired
    );

    modport slave (
        input  tick, run, dir, load, load_value,
        output digits, hex_display, carry_out, done, expired
    );
endinterface

// File: rtl/bcd_timer_chain.sv
// bcd_timer_chain
//   N-digit cascaded BCD up/down counter with a per-digit rollover limit,
//   clamped synchronous preset, zero-saturating countdown with done/expired
//   signalling, and per-digit 7-segment encoding with optional
//   leading-zero blanking.
//
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : bcd_timer_chain_if.slave
//          tick/run/dir/load/load_value in,
//          digits/hex_display/carry_out/done/expired out
module bcd_timer_chain #(
    parameter int          NUM_DIGITS   = 4,
    parameter logic [31:0] DIGIT_LIMITS = 32'h0000_5959,
    parameter bit          LEAD_BLANK   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    bcd_timer_chain_if.slave   bus
);

    localparam int W = 4 * NUM_DIGITS;

    // Elaboration-time parameter checks
    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
            $error("bcd_timer_chain: NUM_DIGITS must be in 1..8");
        end
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_limit_check
            if (DIGIT_LIMITS[4*g +: 4] == 4'd0 || DIGIT_LIMITS[4*g +: 4] > 4'd9) begin : g_bad_limit
                $error("bcd_timer_chain: each digit limit must be in 1..9");
            end
        end
    endgenerate

    function automatic logic [3:0] limit_of(input int idx);
        return DIGIT_LIMITS[4*idx +: 4];
    endfunction

    // Segments a..g in bits 7..1, dp (bit 0) always off
    function automatic logic [7:0] seg_encode(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'd0:    s = 8'hFC;
            4'd1:    s = 8'h60;
            4'd2:    s = 8'hDA;
            4'd3:    s = 8'hF2;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'hB6;
            4'd6:    s = 8'hBE;
            4'd7:    s = 8'hE0;
            4'd8:    s = 8'hFE;
            4'd9:    s = 8'hF6;
            default: s = 8'h02;
        endcase
        return s;
    endfunction

    logic [W-1:0] digits_q, digits_d;
    logic         carry_q,  carry_d;
    logic         done_q,   done_d;
    logic         expired_q, expired_d;

    logic [W-1:0] up_val;
    logic [W-1:0] dn_val;
    logic         all_max;
    logic         all_zero;
    logic         step_q_ok;

    // Candidate up and down values. A digit moves only when every lower
    // digit is at its limit (up) or at zero (down), which is the ripple
    // carry/borrow of the chain expressed combinationally.
    always_comb begin
        logic       lower_max;
        logic       lower_zero;
        logic [3:0] d;
        logic [3:0] lim;
        up_val     = digits_q;
        dn_val     = digits_q;
        lower_max  = 1'b1;
        lower_zero = 1'b1;
        d          = 4'd0;
        lim        = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d   = digits_q[4*i +: 4];
            lim = limit_of(i);
            if (lower_max) begin
                up_val[4*i +: 4] = (d >= lim) ? 4'd0 : d + 4'd1;
            end
            if (lower_zero) begin
                dn_val[4*i +: 4] = (d == 4'd0) ? lim : d - 4'd1;
            end
            lower_max  = lower_max  && (d == lim);
            lower_zero = lower_zero && (d == 4'd0);
        end
        all_max  = lower_max;
        all_zero = lower_zero;
    end

    // load outranks a tick arriving in the same cycle
    assign step_q_ok = bus.tick & bus.run & ~bus.load;

    always_comb begin
        logic [3:0] lv;
        logic [3:0] lim;
        digits_d  = digits_q;
        carry_d   = 1'b0;
        done_d    = 1'b0;
        expired_d = expired_q;
        lv        = 4'd0;
        lim       = 4'd0;
        if (bus.load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                lv  = bus.load_value[4*i +: 4];
                lim = limit_of(i);
                digits_d[4*i +: 4] = (lv > lim) ? lim : lv;
            end
            expired_d = 1'b0;
        end else if (step_q_ok) begin
            if (!bus.dir) begin
                digits_d = up_val;
                carry_d  = all_max;
            end else if (!all_zero) begin
                // Countdown saturates at zero; only the step that lands
                // on zero reports done.
                digits_d = dn_val;
                if (dn_val == '0) begin
                    done_d    = 1'b1;
                    expired_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q  <= '0;
            carry_q   <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            carry_q   <= carry_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    // Display decode straight from the registered digits. Blanking walks
    // down from the top digit while everything seen so far is zero; digit 0
    // always shows.
    always_comb begin
        logic       hi_zero;
        logic [3:0] d;
        logic [7:0] seg;
        hi_zero         = 1'b1;
        d               = 4'd0;
        seg             = 8'h00;
        bus.hex_display = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            d       = digits_q[4*i +: 4];
            hi_zero = hi_zero && (d == 4'd0);
            seg     = seg_encode(d);
            if (LEAD_BLANK && (i > 0) && hi_zero) begin
                seg = 8'h00;
            end
            bus.hex_display[8*i +: 8] = seg;
        end
    end

    assign bus.digits    = digits_q;
    assign bus.carry_out = carry_q;
    assign bus.done      = done_q;
    assign bus.expired   = expired_q;

endmodule

// File: tb/tb_bcd_timer_chain.sv
module tb_bcd_timer_chain;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        run;
    logic        dir;
    logic        load;
    logic [15:0] load_value;

    int total;
    int bad;
    int done_cnt;

    bcd_timer_chain_if #(.NUM_DIGITS(4)) bus0 ();
    bcd_timer_chain_if #(.NUM_DIGITS(4)) bus1 ();

    assign bus0.tick = tick;  assign bus1.tick = tick;
    assign bus0.run  = run;   assign bus1.run  = run;
    assign bus0.dir  = dir;   assign bus1.dir  = dir;
    assign bus0.load = load;  assign bus1.load = load;
    assign bus0.load_value = load_value;
    assign bus1.load_value = load_value;

    bcd_timer_chain #(
        .NUM_DIGITS(4), .DIGIT_LIMITS(32'h0000_5959), .LEAD_BLANK(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    bcd_timer_chain #(
        .NUM_DIGITS(4), .DIGIT_LIMITS(32'h0000_5959), .LEAD_BLANK(1'b1)
    ) dut_blank (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0; bad = 0; done_cnt = 0;
        rst = 1'b1; tick = 1'b0; run = 1'b0; dir = 1'b0; load = 1'b0;
        load_value = 16'h0000;
        #18;
        rst = 1'b0;
        cyc();

        // Reset defaults
        check("rst_digits",  64'(bus0.digits), 64'(16'h0000));
        check("rst_hex",     64'(bus0.hex_display), 64'(32'hFCFC_FCFC));
        check("rst_hex_blk", 64'(bus1.hex_display), 64'(32'h0000_00FC));
        check("rst_flags",   64'({bus0.carry_out, bus0.done, bus0.expired}), 64'(3'b000));

        // Countdown from 3:00
        load = 1'b1; load_value = 16'h0300; dir = 1'b1; run = 1'b1;
        cyc();
        load = 1'b0;
        check("load_0300", 64'(bus0.digits), 64'(16'h0300));
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        check("down_259",     64'(bus0.digits), 64'(16'h0259));
        check("down_259_blk", 64'(bus1.hex_display), 64'(32'h00DA_B6F6));
        check("down_259_done", 64'(bus0.done), 64'(1'b0));
        tick = 1'b1;
        for (int i = 0; i < 179; i++) begin
            cyc();
            if (bus0.done) done_cnt++;
            if (i == 58) check("down_200", 64'(bus0.digits), 64'(16'h0200));
        end
        check("down_zero",    64'(bus0.digits), 64'(16'h0000));
        check("down_done_at0", 64'(bus0.done), 64'(1'b1));
        check("down_expired", 64'(bus0.expired), 64'(1'b1));
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (bus0.done) done_cnt++;
        end
        tick = 1'b0;
        check("sat_digits",  64'(bus0.digits), 64'(16'h0000));
        check("done_once",   64'(done_cnt), 64'(1));
        check("sat_expired", 64'(bus0.expired), 64'(1'b1));

        // Up-count wrap
        dir = 1'b0; load = 1'b1; load_value = 16'h5958;
        cyc();
        load = 1'b0;
        check("up_load",        64'(bus0.digits), 64'(16'h5958));
        check("load_clr_exp",   64'(bus0.expired), 64'(1'b0));
        check("load_no_carry",  64'(bus0.carry_out), 64'(1'b0));
        tick = 1'b1;
        cyc();
        check("up_5959",        64'(bus0.digits), 64'(16'h5959));
        check("up_5959_carry",  64'(bus0.carry_out), 64'(1'b0));
        cyc();
        tick = 1'b0;
        check("up_wrap",        64'(bus0.digits), 64'(16'h0000));
        check("up_carry",       64'(bus0.carry_out), 64'(1'b1));
        cyc();
        check("up_carry_pulse", 64'(bus0.carry_out), 64'(1'b0));

        // Clamped load, then load beating a tick
        load = 1'b1; load_value = 16'h7A9F;
        cyc();
        check("clamp",          64'(bus0.digits), 64'(16'h5959));
        load_value = 16'h1234; tick = 1'b1;
        cyc();
        load = 1'b0; tick = 1'b0;
        check("load_wins",      64'(bus0.digits), 64'(16'h1234));
        check("hex_1234",       64'(bus0.hex_display), 64'(32'h60DA_F266));

        // Hold with run low
        run = 1'b0; tick = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        tick = 1'b0;
        check("run_hold",       64'(bus0.digits), 64'(16'h1234));

        // Leading-zero blanking
        run = 1'b1; load = 1'b1; load_value = 16'h0042;
        cyc();
        load = 1'b0;
        check("blank_0042",     64'(bus1.hex_display), 64'(32'h0000_66DA));
        check("noblank_0042",   64'(bus0.hex_display), 64'(32'hFCFC_66DA));

        // Expire at 0:01 -> 0:00, count up to 0:03, then count down one step
        dir = 1'b1; load = 1'b1; load_value = 16'h0001;
        cyc();
        load = 1'b0; tick = 1'b1;
        cyc();
        dir = 1'b0;
        cyc(); cyc(); cyc();
        dir = 1'b1;
        cyc();
        tick = 1'b0;
        check("pre_rst_digits",  64'(bus0.digits), 64'(16'h0002));
        check("pre_rst_expired", 64'(bus0.expired), 64'(1'b1));

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check("arst_digits",  64'(bus0.digits), 64'(16'h0000));
        check("arst_flags",   64'({bus0.carry_out, bus0.done, bus0.expired}), 64'(3'b000));
        check("arst_hex_blk", 64'(bus1.hex_display), 64'(32'h0000_00FC));
        #2;
        rst = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_timer_chain.md
Name: bcd_timer_chain

Overview:
Parametrised N-digit BCD up/down counter chain with per-digit rollover limits and per-digit 7-segment encoding. It is the generalised successor of the single-digit decoder stage. It drives the ramen timer display directly, e.g. mm:ss with limits 5,9,5,9. It adds presettable load, a countdown mode that saturates at zero, expiry signalling, and optional leading-zero blanking.

Parameters:
NUM_DIGITS, 4, number of cascaded BCD digits (1..8); digit 0 is least significant
DIGIT_LIMITS, 32'h0000_5959, packed 4 bits per digit, digit i at [4i+3:4i]; rollover maximum per digit; legal range 1..9
LEAD_BLANK, 0, 1 = blank zero digits above the most significant non-zero digit (digit 0 never blanked)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
tick  input  1  single-cycle count enable (e.g. 1 Hz strobe)
run  input  1  1 = counting permitted; 0 = hold
dir  input  1  0 = count up, 1 = count down
load  input  1  synchronous preset strobe
load_value  input  4*NUM_DIGITS  preset digits, same packing as DIGIT_LIMITS
digits  output  4*NUM_DIGITS  current BCD value, registered
hex_display  output  8*NUM_DIGITS  per-digit segments, bit7=a .. bit1=g, bit0=dp (always 0), active-high
carry_out  output  1  one-cycle pulse on up-count wrap from all-max to all-zero
done  output  1  one-cycle pulse when a down-count reaches all-zero
expired  output  1  sticky: set with done, cleared by load or rst

Behaviour:
- Reset (async assert, sync-release usage): digits=0, carry_out=0, done=0, expired=0. hex_display shows "0" on digit 0. Other digits show "0" (LEAD_BLANK=0) or blank (LEAD_BLANK=1).
- Priority per cycle: rst > load > (tick & run). tick is ignored when run=0 or load=1.
- Load: on the next edge, digit i := min(load_value[i], limit[i]). Clears expired. No carry_out or done is generated.
- Up step (dir=0): digit 0 increments. Digit i increments iff all lower digits equal their limits. A digit at its limit whose lower digits are all at their limits wraps to 0.
  - All digits at limit: the whole chain wraps to 0 and carry_out=1 in the following cycle (registered, 1-cycle pulse).
- Down step (dir=1): digit 0 decrements. Digit i decrements iff all lower digits are 0. A 0 digit that borrows reloads to its limit.
  - Chain already all-zero: value holds (saturate). No done pulse, no wrap.
  - Step that makes the chain all-zero: done=1 in the following cycle (1 cycle), expired:=1 on the same edge as done.
- dir may change between ticks. It is sampled only on a qualified tick.
- carry_out and done are each high for exactly one cycle per event. Consecutive events give separate pulses.
- Segment encoding (abcdefg.dp): 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6. Any value >9 gives 0x02 (g only, error dash).
  - hex_display is combinational from the registered digits, so display latency is 0 cycles after the digits update.
- Blanking (LEAD_BLANK=1): digit i>0 outputs 0x00 when it and all higher digits are 0.
- Reset mid-count: all state clears immediately, regardless of tick, run or load.
- Parameter check: elaboration error if any limit is 0 or >9, or if NUM_DIGITS is outside 1..8.

Test Plan:
- Reset release, defaults -> digits=0x0000, hex_display=0xFCFCFCFC, carry_out=done=expired=0.
- load_value=0x0300, dir=1, run=1, one tick -> digits=0x0259 (2:59). Tick 179 more times -> digits=0x0000, done pulses exactly once, expired=1. Further ticks -> digits stay 0x0000, no second done.
- dir=0, load 0x5958, two ticks -> 0x5959, then 0x0000 with carry_out=1 for one cycle.
- load_value=0x7A9F with limits 0x5959 -> digits=0x5959 (clamped). load and tick asserted together -> load wins, no step.
- run=0 with 10 ticks -> value unchanged. LEAD_BLANK=1, load 0x0042 -> hex_display=0x000066DA.
- rst asserted asynchronously between edges mid-countdown with expired=1 -> outputs clear before the next edge.
